// File: rtl/dma_axil_mem_responder.sv
// Single-port word memory behind a simple AXI-Lite-like request/response
// handshake. One access in flight, fixed write/read latency, abort support,
// and alternating priority when a write and a read arrive together.
module dma_axil_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned WR_LATENCY = 1,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  aenable,
  input  logic                  i_abort,
  input  logic                  i_axil_wvalid,
  input  logic [STRB_WIDTH-1:0] i_axil_wstrb,
  input  logic [DATA_WIDTH-1:0] i_axil_wdata,
  input  logic [ADDR_WIDTH-1:0] i_axil_waddr,
  output logic                  o_axil_wready,
  input  logic                  i_axil_rready,
  input  logic [ADDR_WIDTH-1:0] i_axil_raddr,
  output logic                  o_axil_rvalid,
  output logic [DATA_WIDTH-1:0] o_axil_rdata,
  output logic                  o_addr_err
);

  localparam int unsigned OFF_W    = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam int unsigned HI_SHIFT = OFF_W + IDX_W;

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, ABORTING} state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  prio_wr_q, prio_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic                  commit_q, commit_d;
  logic                  wready_q, wready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [IDX_W-1:0]      word_idx;
  logic                  addr_err;
  logic                  grant_wr;

  // Word index and range check of the registered address
  always_comb begin
    word_idx = IDX_W'(addr_q >> OFF_W);
    addr_err = |(addr_q >> HI_SHIFT);
  end

  // Next-state, capture and response computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_wr_d = prio_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    commit_d  = 1'b0;
    wready_d  = 1'b0;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    grant_wr  = i_axil_wvalid && (!i_axil_rready || prio_wr_q);
    unique case (state_q)
      IDLE: begin
        if (i_abort) begin
          state_d = ABORTING;
        end else if (aenable && (i_axil_wvalid || i_axil_rready)) begin
          if (i_axil_wvalid && i_axil_rready) prio_wr_d = !prio_wr_q;
          if (grant_wr) begin
            state_d = WR_WAIT;
            addr_d  = i_axil_waddr;
            data_d  = i_axil_wdata;
            strb_d  = i_axil_wstrb;
            cnt_d   = 4'(WR_LATENCY - 1);
          end else begin
            state_d = RD_WAIT;
            addr_d  = i_axil_raddr;
            cnt_d   = 4'(RD_LATENCY - 1);
          end
        end
      end
      WR_WAIT: begin
        if (i_abort) begin
          state_d = ABORTING;
        end else if (cnt_q == '0) begin
          // Back to IDLE during the pulse cycle so the next accept can land
          // on the edge that ends it; the array write is deferred to that edge.
          state_d  = IDLE;
          wready_d = 1'b1;
          err_d    = addr_err;
          commit_d = !addr_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_WAIT: begin
        if (i_abort) begin
          state_d = ABORTING;
        end else if (cnt_q == '0) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = addr_err;
          rdata_d  = addr_err ? '0 : mem[word_idx];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ABORTING: begin
        if (!i_abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prio_wr_q <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      commit_q  <= 1'b0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_wr_q <= prio_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      commit_q  <= commit_d;
      wready_q  <= wready_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Byte-masked array write at the end of the wready pulse cycle
  always_ff @(posedge aclk) begin
    if (commit_q) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (strb_q[b]) mem[word_idx][8*b +: 8] <= data_q[8*b +: 8];
      end
    end
  end

  assign o_axil_wready = wready_q;
  assign o_axil_rvalid = rvalid_q;
  assign o_axil_rdata  = rdata_q;
  assign o_addr_err    = err_q;

endmodule

// File: tb/tb_dma_axil_mem_responder.sv
// Bench for dma_axil_mem_responder: directed vector table, hand-written
// priority/abort/reset sequences, and randomized traffic against a word model.
module tb_dma_axil_mem_responder;

  localparam int WRL = 1;
  localparam int RDL = 2;

  logic        aclk = 1'b0;
  logic        areset, aenable, i_abort;
  logic        i_axil_wvalid, i_axil_rready;
  logic [7:0]  i_axil_wstrb;
  logic [63:0] i_axil_wdata;
  logic [15:0] i_axil_waddr, i_axil_raddr;
  logic        o_axil_wready, o_axil_rvalid, o_addr_err;
  logic [63:0] o_axil_rdata;

  dma_axil_mem_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(64), .STRB_WIDTH(8),
    .MEM_DEPTH(256), .WR_LATENCY(WRL), .RD_LATENCY(RDL)
  ) dut (
    .aclk(aclk), .areset(areset), .aenable(aenable), .i_abort(i_abort),
    .i_axil_wvalid(i_axil_wvalid), .i_axil_wstrb(i_axil_wstrb),
    .i_axil_wdata(i_axil_wdata), .i_axil_waddr(i_axil_waddr),
    .o_axil_wready(o_axil_wready), .i_axil_rready(i_axil_rready),
    .i_axil_raddr(i_axil_raddr), .o_axil_rvalid(o_axil_rvalid),
    .o_axil_rdata(o_axil_rdata), .o_addr_err(o_addr_err)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        vt [15];
  logic [63:0] ref_mem [8];

  int          lat, cnt, idx, hold, gaps;
  logic [63:0] rd, expd;
  logic        err, side, acc, wr;
  logic [15:0] addr;
  logic [63:0] data;
  logic [7:0]  strb;
  bit          ptype [$];
  int          pcyc [$];

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one request, optionally with aenable held low for hold_off edges,
  // and wait (bounded) for its completion pulse.
  task automatic do_txn(input bit t_wr, input logic [15:0] t_addr, input logic [63:0] t_data,
                        input logic [7:0] t_strb, input int hold_off,
                        output int t_lat, output logic [63:0] t_rd, output logic t_err,
                        output logic t_side);
    t_side = 1'b0;
    t_rd   = '0;
    t_err  = 1'b0;
    aenable = (hold_off == 0);
    if (t_wr) begin
      i_axil_wvalid = 1'b1; i_axil_waddr = t_addr; i_axil_wdata = t_data; i_axil_wstrb = t_strb;
    end else begin
      i_axil_rready = 1'b1; i_axil_raddr = t_addr;
    end
    t_lat = 0;
    while (t_lat < 40) begin
      step();
      t_lat++;
      if (t_lat == hold_off) aenable = 1'b1;
      if ((t_wr ? o_axil_wready : o_axil_rvalid)) begin
        if (t_wr ? o_axil_rvalid : o_axil_wready) t_side = 1'b1;
        t_rd  = o_axil_rdata;
        t_err = o_addr_err;
        break;
      end
      if (o_axil_wready || o_axil_rvalid || o_addr_err || (o_axil_rdata != 0)) t_side = 1'b1;
    end
    i_axil_wvalid = 1'b0;
    i_axil_rready = 1'b0;
    aenable = 1'b1;
  endtask

  initial begin
    areset = 1'b1; aenable = 1'b1; i_abort = 1'b0;
    i_axil_wvalid = 1'b0; i_axil_rready = 1'b0;
    i_axil_wstrb = '0; i_axil_wdata = '0; i_axil_waddr = '0; i_axil_raddr = '0;

    vt[0]  = '{1'b1, 16'h0010, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    vt[1]  = '{1'b0, 16'h0010, 64'h0, 8'h00, 64'h1122334455667788, 1'b0};
    vt[2]  = '{1'b1, 16'h0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
    vt[3]  = '{1'b0, 16'h0010, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vt[4]  = '{1'b1, 16'h0000, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
    vt[5]  = '{1'b0, 16'h0800, 64'h0, 8'h00, 64'h0, 1'b1};
    vt[6]  = '{1'b1, 16'h0800, 64'hDEADBEEFDEADBEEF, 8'hFF, 64'h0, 1'b1};
    vt[7]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
    vt[8]  = '{1'b0, 16'h0013, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vt[9]  = '{1'b1, 16'h07F8, 64'hCAFEF00D12345678, 8'hFF, 64'h0, 1'b0};
    vt[10] = '{1'b0, 16'h07FF, 64'h0, 8'h00, 64'hCAFEF00D12345678, 1'b0};
    vt[11] = '{1'b1, 16'h0010, 64'h0, 8'h00, 64'h0, 1'b0};
    vt[12] = '{1'b0, 16'h0010, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vt[13] = '{1'b1, 16'hFFF8, 64'h5555555555555555, 8'hFF, 64'h0, 1'b1};
    vt[14] = '{1'b0, 16'hFFF8, 64'h0, 8'h00, 64'h0, 1'b1};

    step(); step();
    chk("reset_outputs", {o_axil_wready, o_axil_rvalid, o_addr_err, o_axil_rdata}, '0);
    areset = 1'b0;
    step();

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      do_txn(vt[i].wr, vt[i].addr, vt[i].data, vt[i].strb, 0, lat, rd, err, side);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].wr ? WRL + 1 : RDL + 1));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vt[i].exp_err));
      chk($sformatf("vec%0d_side", i), 64'(side), 64'h0);
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
    end

    // Simultaneous write/read requests held high: grants must alternate
    areset = 1'b1;
    step();
    chk("reset2_outputs", {o_axil_wready, o_axil_rvalid, o_addr_err, o_axil_rdata}, '0);
    areset = 1'b0;
    i_axil_wvalid = 1'b1; i_axil_waddr = 16'h0020; i_axil_wdata = 64'h0BADC0DE0BADC0DE; i_axil_wstrb = 8'hFF;
    i_axil_rready = 1'b1; i_axil_raddr = 16'h0010;
    acc = 1'b0;
    for (int c = 1; c <= 60 && ptype.size() < 8; c++) begin
      step();
      if (o_axil_wready && o_axil_rvalid) acc = 1'b1;
      if (o_axil_rvalid && o_axil_rdata != 64'h11223344AAAAAAAA) acc = 1'b1;
      if (o_axil_wready || o_axil_rvalid) begin
        ptype.push_back(o_axil_wready);
        pcyc.push_back(c);
      end
    end
    i_axil_wvalid = 1'b0; i_axil_rready = 1'b0;
    chk("prio_pulse_count", 64'(ptype.size()), 64'd8);
    chk("prio_overlap_or_rdata", 64'(acc), 64'h0);
    if (ptype.size() == 8) begin
      chk("prio_first_pulse_cycle", 64'(pcyc[0]), 64'(WRL + 1));
      for (int i = 0; i < 8; i++) chk($sformatf("prio_grant%0d", i), 64'(ptype[i]), 64'(i % 2 == 0));
      for (int i = 1; i < 8; i++)
        chk($sformatf("prio_gap%0d", i), 64'(pcyc[i] - pcyc[i-1]), 64'(ptype[i-1] ? RDL + 1 : WRL + 1));
    end
    step();

    // Abort a write one cycle after accept, hold abort for 3 cycles
    do_txn(1'b1, 16'h0018, 64'h0F0E0D0C0B0A0908, 8'hFF, 0, lat, rd, err, side);
    chk("abort_prep_latency", 64'(lat), 64'(WRL + 1));
    i_axil_wvalid = 1'b1; i_axil_waddr = 16'h0018; i_axil_wdata = 64'hFFFFFFFFFFFFFFFF; i_axil_wstrb = 8'hFF;
    step();
    i_axil_wvalid = 1'b0; i_abort = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      acc = acc | o_axil_wready | o_axil_rvalid;
    end
    i_abort = 1'b0;
    i_axil_rready = 1'b1; i_axil_raddr = 16'h0018;
    cnt = 0;
    while (cnt < 20) begin
      step();
      cnt++;
      if (o_axil_rvalid) break;
      acc = acc | o_axil_wready;
    end
    rd = o_axil_rdata;
    i_axil_rready = 1'b0;
    chk("abort_no_pulse", 64'(acc), 64'h0);
    chk("abort_resume_latency", 64'(cnt), 64'(RDL + 2));
    chk("abort_word_unchanged", rd, 64'h0F0E0D0C0B0A0908);

    // Abort sampled in the cycle the read counter reaches zero
    i_axil_rready = 1'b1; i_axil_raddr = 16'h0018;
    step();
    i_axil_rready = 1'b0;
    acc = 1'b0;
    step();
    acc = acc | o_axil_rvalid;
    i_abort = 1'b1;
    step();
    acc = acc | o_axil_rvalid;
    i_abort = 1'b0;
    step(); acc = acc | o_axil_rvalid;
    step(); acc = acc | o_axil_rvalid;
    chk("abort_at_zero_no_pulse", 64'(acc), 64'h0);
    do_txn(1'b0, 16'h0018, 64'h0, 8'h00, 0, lat, rd, err, side);
    chk("abort_at_zero_recover_lat", 64'(lat), 64'(RDL + 1));
    chk("abort_at_zero_recover_data", rd, 64'h0F0E0D0C0B0A0908);

    // Reset during RD_WAIT, then aenable gating
    i_axil_rready = 1'b1; i_axil_raddr = 16'h0010;
    step();
    i_axil_rready = 1'b0; areset = 1'b1;
    step();
    chk("reset_in_rd_outputs", {o_axil_wready, o_axil_rvalid, o_addr_err, o_axil_rdata}, '0);
    areset = 1'b0;
    acc = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      acc = acc | o_axil_rvalid | o_axil_wready;
    end
    chk("reset_in_rd_no_pulse", 64'(acc), 64'h0);
    aenable = 1'b0;
    i_axil_wvalid = 1'b1; i_axil_waddr = 16'h0028; i_axil_wdata = 64'h7766554433221100; i_axil_wstrb = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      step();
      acc = acc | o_axil_wready;
    end
    chk("aenable_low_blocks", 64'(acc), 64'h0);
    aenable = 1'b1;
    cnt = 0;
    while (cnt < 20) begin
      step();
      cnt++;
      if (o_axil_wready) break;
    end
    i_axil_wvalid = 1'b0;
    chk("aenable_rise_latency", 64'(cnt), 64'(WRL + 1));
    do_txn(1'b0, 16'h0028, 64'h0, 8'h00, 0, lat, rd, err, side);
    chk("aenable_write_landed", rd, 64'h7766554433221100);

    // Randomized traffic against a word-level model
    for (int w = 0; w < 8; w++) begin
      ref_mem[w] = {$urandom, $urandom};
      do_txn(1'b1, 16'(w * 8), ref_mem[w], 8'hFF, 0, lat, rd, err, side);
      chk("rand_init_latency", 64'(lat), 64'(WRL + 1));
    end
    for (int t = 0; t < 150; t++) begin
      wr   = 1'($urandom_range(0, 1));
      idx  = ($urandom_range(0, 9) == 0) ? 256 + int'($urandom_range(0, 7)) : int'($urandom_range(0, 7));
      addr = 16'(idx * 8 + int'($urandom_range(0, 7)));
      data = {$urandom, $urandom};
      strb = 8'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_txn(wr, addr, data, strb, hold, lat, rd, err, side);
      chk($sformatf("rand%0d_latency", t), 64'(lat), 64'(hold + 1 + (wr ? WRL : RDL)));
      chk($sformatf("rand%0d_err", t), 64'(err), 64'(idx >= 256));
      chk($sformatf("rand%0d_side", t), 64'(side), 64'h0);
      if (wr) begin
        if (idx < 256)
          for (int b = 0; b < 8; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      end else begin
        expd = (idx < 256) ? ref_mem[idx] : 64'h0;
        chk($sformatf("rand%0d_rdata", t), rd, expd);
      end
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_axil_mem_responder.md
DMA_AXIL_MEM_RESPONDER -- requirements
Module: dma_axil_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width; legal values 32 and 64.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte-strobe width.
REQ-004 SHALL have parameter MEM_DEPTH, default 256, number of words; power of two.
REQ-005 SHALL have parameter WR_LATENCY, default 1, cycles from accept to o_axil_wready; range 1..15.
REQ-006 SHALL have parameter RD_LATENCY, default 2, cycles from accept to o_axil_rvalid; range 1..15.
REQ-007 SHALL have the following ports:
- aclk  in  1  single clock; all logic on the rising edge.
- areset  in  1  reset; synchronous, active-high.
- aenable  in  1  when low, no new request is accepted.
- i_abort  in  1  cancels the in-flight access.
- i_axil_wvalid  in  1  write request; held until o_axil_wready.
- i_axil_wstrb  in  STRB_WIDTH  byte enables.
- i_axil_wdata  in  DATA_WIDTH  write data.
- i_axil_waddr  in  ADDR_WIDTH  write byte address.
- o_axil_wready  out  1  one-cycle write completion pulse.
- i_axil_rready  in  1  read request; held until o_axil_rvalid.
- i_axil_raddr  in  ADDR_WIDTH  read byte address.
- o_axil_rvalid  out  1  one-cycle read completion pulse.
- o_axil_rdata  out  DATA_WIDTH  read data; valid only with o_axil_rvalid.
- o_addr_err  out  1  pulses with wready/rvalid when the address is out of range.

Function
REQ-008 SHALL hold a single-port MEM_DEPTH x DATA_WIDTH array; one access in flight at a time.
REQ-009 SHALL compute word index = addr >> log2(STRB_WIDTH); index >= MEM_DEPTH is out of range.
REQ-010 SHALL ignore low address bits below the word boundary; no unaligned handling.
REQ-011 SHALL implement the FSM IDLE, WR_WAIT, RD_WAIT, ABORTING.
REQ-012 IDLE: if i_abort, go to ABORTING; else if aenable and a request is present, accept it.
  - A write is accepted into WR_WAIT; a read into RD_WAIT.
  - Address, data and strobe are registered at accept.
  - The latency counter loads WR_LATENCY-1 or RD_LATENCY-1.
REQ-013 IDLE, wvalid and rready both high: SHALL grant the type not granted last; the priority flag toggles on each grant of a simultaneous pair.
REQ-014 For an accept at edge T: the response pulse SHALL be high for exactly the cycle T+WR_LATENCY or T+RD_LATENCY.
  - The FSM returns to IDLE at the end of the pulse cycle.
  - The earliest next accept is the following edge, so back-to-back throughput is 1 transaction per LATENCY+1 cycles.
REQ-015 Write commit: SHALL occur on the edge that ends the wready pulse cycle.
  - Only bytes with the strobe bit set are updated; wstrb = 0 is a completed no-op.
REQ-016 Read data: SHALL be sampled from the array at response time, reflecting all previously completed writes.
  - o_axil_rdata SHALL be 0 whenever o_axil_rvalid is low.
REQ-017 Out-of-range write: no array update; wready pulses with o_addr_err=1.
REQ-018 Out-of-range read: rdata=0; rvalid pulses with o_addr_err=1.
REQ-019 i_abort high in any cycle while in WR_WAIT or RD_WAIT:
  - Go to ABORTING at the next edge.
  - Issue no response pulse and no array write.
  - Abort sampled in the same cycle the counter reaches 0 still cancels.
REQ-020 ABORTING: no accepts; return to IDLE on the first cycle with i_abort low; the priority flag is unchanged.
REQ-021 aenable low SHALL block accepts only; an in-flight access completes normally.
REQ-022 Request inputs changing or dropping while in WAIT SHALL NOT affect the in-flight access.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 On areset high at an edge:
  - State = IDLE; counter = 0; priority flag favours write.
  - o_axil_wready, o_axil_rvalid, o_addr_err = 0; o_axil_rdata = 0.
REQ-025 Reset mid-transaction SHALL drop the access with no pulse and no write; array contents SHALL NOT be reset.

Verification
REQ-026 Write 0x1122334455667788 to addr 0x0010 with strb 0xFF, then read 0x0010 -> wready pulse at T+1; rvalid pulse at T'+2; rdata = 0x1122334455667788; o_addr_err = 0.
REQ-027 Write 0xAAAA...AA with strb 0x0F to the word above, then read -> rdata = 0x11223344AAAAAAAA.
REQ-028 wvalid and rready asserted together in IDLE for 4 consecutive transactions each -> grants alternate W,R,W,R; no pulse overlaps; 1 idle cycle between accepts.
REQ-029 Read addr 0x0800 (index 256 with MEM_DEPTH=256) -> rvalid with rdata = 0 and o_addr_err = 1; a write to the same address leaves word 0 unchanged.
REQ-030 Abort the write to 0x0018 one cycle after accept; deassert abort after 3 cycles -> no wready, word unchanged; ABORTING for 3 cycles, then IDLE and a new accept.
REQ-031 areset in RD_WAIT; also aenable low with wvalid high -> no rvalid after reset and all outputs 0; no accept until aenable rises, then wready after WR_LATENCY.
